// File: rtl/pwm_cfg_seq.sv
// pwm_cfg_seq: single-master Wishbone sequencer that reprograms one pwm_timer
// channel. The sequence is: quiesce the counter, write period and duty,
// re-enable with the requested control byte, then read the period back.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a command, o_req_ready high
// W_CTRL0  | write CTRL with counter_enable (bit 2) cleared
// GAP      | one idle bus cycle, successor taken from step_q
// W_PER    | write PERIODn
// W_DC     | write DCn
// W_CTRL1  | write CTRL with the requested control byte
// R_PER    | read PERIODn back, compare against the captured period
// DONE     | result pulse cycle (o_done or o_err), then back to IDLE
module pwm_cfg_seq #(
    parameter logic [15:0] BASE    = 16'h0000,
    parameter int          TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_ch,
    input  logic [15:0] i_req_period,
    input  logic [15:0] i_req_dc,
    input  logic [7:0]  i_req_ctrl,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [15:0] o_wb_adr,
    output logic [15:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [15:0] i_wb_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_CTRL0,
        ST_GAP,
        ST_W_PER,
        ST_W_DC,
        ST_W_CTRL1,
        ST_R_PER,
        ST_DONE
    } state_t;

    // Last counter value before an unacknowledged access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_READBACK = 2'b10;

    state_t      state_q, state_d;
    state_t      step_q, step_d;
    logic [1:0]  ch_q, ch_d;
    logic [15:0] per_q, per_d;
    logic [15:0] dc_q, dc_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [15:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;

    logic        accept;
    logic        access;
    logic [15:0] per_adr;
    logic [15:0] dc_adr;

    // Next-state, command capture, timeout and next-cycle bus outputs.
    // Bus outputs are decoded from state_d so they are registered alongside
    // the state and never follow i_wb_ack combinationally.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ch_d    = ch_q;
        per_d   = per_q;
        dc_d    = dc_q;
        ctrl_d  = ctrl_q;
        tmo_d   = 8'd0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = 16'h0000;
        wdat_d  = 16'h0000;
        per_adr = 16'h0000;
        dc_adr  = 16'h0000;

        accept = i_req_valid & ready_q;
        access = (state_q == ST_W_CTRL0) || (state_q == ST_W_PER) ||
                 (state_q == ST_W_DC)    || (state_q == ST_W_CTRL1) ||
                 (state_q == ST_R_PER);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ch_d    = i_req_ch;
                    per_d   = i_req_period;
                    dc_d    = i_req_dc;
                    ctrl_d  = i_req_ctrl;
                    code_d  = 2'b00;
                    state_d = ST_W_CTRL0;
                end
            end
            ST_GAP:     state_d = step_q;
            ST_W_CTRL0: step_d  = ST_W_PER;
            ST_W_PER:   step_d  = ST_W_DC;
            ST_W_DC:    step_d  = ST_W_CTRL1;
            ST_W_CTRL1: step_d  = ST_R_PER;
            ST_R_PER:   step_d  = ST_IDLE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Acknowledge wins over a timeout landing on the same edge.
        if (access) begin
            if (i_wb_ack) begin
                if (state_q == ST_R_PER) begin
                    state_d = ST_DONE;
                    if (i_wb_data == per_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_READBACK;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end else if (tmo_q == TMO_LAST) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end

        per_adr = BASE + 16'd4 + {12'd0, ch_d, 2'b00};
        dc_adr  = per_adr + 16'd2;

        case (state_d)
            ST_W_CTRL0: begin
                cyc_d  = 1'b1;
                we_d   = 1'b1;
                adr_d  = BASE;
                wdat_d = {8'h00, ctrl_d & 8'hFB};
            end
            ST_W_PER: begin
                cyc_d  = 1'b1;
                we_d   = 1'b1;
                adr_d  = per_adr;
                wdat_d = per_d;
            end
            ST_W_DC: begin
                cyc_d  = 1'b1;
                we_d   = 1'b1;
                adr_d  = dc_adr;
                wdat_d = dc_d;
            end
            ST_W_CTRL1: begin
                cyc_d  = 1'b1;
                we_d   = 1'b1;
                adr_d  = BASE;
                wdat_d = {8'h00, ctrl_d};
            end
            ST_R_PER: begin
                cyc_d  = 1'b1;
                adr_d  = per_adr;
            end
            default: begin
                cyc_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State, captured command and registered outputs; reset drops the bus at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            step_q  <= ST_IDLE;
            ch_q    <= 2'd0;
            per_q   <= 16'h0000;
            dc_q    <= 16'h0000;
            ctrl_q  <= 8'h00;
            tmo_q   <= 8'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 16'h0000;
            wdat_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ch_q    <= ch_d;
            per_q   <= per_d;
            dc_q    <= dc_d;
            ctrl_q  <= ctrl_d;
            tmo_q   <= tmo_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_err_code  = code_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_wb_we     = we_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_data   = wdat_q;

endmodule
